// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, data requester and memory-side signals around the
// shared memory port; slave is the arbiter's view, master is the surrounding system's.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          owner_dm;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, owner_dm
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner_dm
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch (if) and data (dm);
// dm has priority, and a streak counter forces a fetch after STARVE_MAX back-to-back dm grants.
module mem_port_arbiter #(
    parameter  int AW         = 32,
    parameter  int DW         = 32,
    parameter  int MEM_LAT    = 2,
    parameter  int STARVE_MAX = 3,
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]        dbg_state_o,
    output logic [SW-1:0]     dbg_streak_o
);
    // Handshake: a requester raises req with its fields and holds req until its one-cycle
    // ack. Fields are latched at grant (IDLE only); later changes are ignored. ack is the
    // only completion indication, and req is never sampled outside IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT);

    state_e        state_q,     state_d;
    logic [3:0]    cnt_q,       cnt_d;
    logic [SW-1:0] streak_q,    streak_d;
    logic          owner_dm_q,  owner_dm_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] dm_rdata_q,  dm_rdata_d;

    logic streak_at_max;
    logic dm_wins;

    assign streak_at_max = (streak_q == SW'(STARVE_MAX));
    assign dm_wins       = bus.dm_req && !(bus.if_req && streak_at_max);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            owner_dm_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            owner_dm_q  <= owner_dm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        owner_dm_d  = owner_dm_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (dm_wins) begin
                    state_d     = S_ISSUE;
                    owner_dm_d  = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    // The streak only grows while a fetch is actually being held off.
                    if (bus.if_req) begin
                        streak_d = streak_at_max ? streak_q : streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (bus.if_req) begin
                    state_d    = S_ISSUE;
                    owner_dm_d = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    streak_d   = '0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CNT_INIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    if (!mem_we_q) begin
                        if (owner_dm_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_en    = (state_q == S_ISSUE);
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.if_ack    = (state_q == S_RESP) && !owner_dm_q;
        bus.dm_ack    = (state_q == S_RESP) && owner_dm_q;
        bus.if_rdata  = if_rdata_q;
        bus.dm_rdata  = dm_rdata_q;
        bus.busy      = (state_q != S_IDLE);
        bus.owner_dm  = owner_dm_q;
        dbg_state_o   = state_q;
        dbg_streak_o  = streak_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for the functional cases, plus
// MEM_LAT=1 and MEM_LAT=15 instances for back-to-back fetch timing.
module tb_mem_port_arbiter;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus2  ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus1  ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus15 ();

    logic [1:0] state2, state1, state15;
    logic [1:0] streak2, streak1, streak15;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(3)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2),
        .dbg_state_o(state2), .dbg_streak_o(streak2)
    );
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1),
        .dbg_state_o(state1), .dbg_streak_o(streak1)
    );
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(15), .STARVE_MAX(3)) u_dut15 (
        .clock(clock), .reset_n(reset_n), .bus(bus15),
        .dbg_state_o(state15), .dbg_streak_o(streak15)
    );

    // ---------------- memory models ----------------
    // Word at address a defaults to {C0, a, 0F, a}; reads outside a valid slot give POISON.
    logic [31:0] mem [256];
    logic [31:0] pipe2 [16];
    logic [31:0] pipe1 [16];
    logic [31:0] pipe15 [16];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i), 8'h0F, 8'(i)};
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h40] = 32'hCAFE_F00D;
    end

    always @(posedge clock) begin
        for (int i = 15; i > 0; i--) begin
            pipe2[i]  <= pipe2[i-1];
            pipe1[i]  <= pipe1[i-1];
            pipe15[i] <= pipe15[i-1];
        end
        pipe2[0]  <= bus2.mem_en  ? mem[bus2.mem_addr[7:0]]  : POISON;
        pipe1[0]  <= bus1.mem_en  ? mem[bus1.mem_addr[7:0]]  : POISON;
        pipe15[0] <= bus15.mem_en ? mem[bus15.mem_addr[7:0]] : POISON;
        if (bus2.mem_en && bus2.mem_we) mem[bus2.mem_addr[7:0]] <= bus2.mem_wdata;
    end

    assign bus2.mem_rdata  = pipe2[1];
    assign bus1.mem_rdata  = pipe1[0];
    assign bus15.mem_rdata = pipe15[14];

    logic        bb_en   [2];
    logic        bb_ack  [2];
    logic [31:0] bb_maddr[2];
    logic [31:0] bb_rdata[2];
    assign bb_en[0]    = bus1.mem_en;
    assign bb_en[1]    = bus15.mem_en;
    assign bb_ack[0]   = bus1.if_ack;
    assign bb_ack[1]   = bus15.if_ack;
    assign bb_maddr[0] = bus1.mem_addr;
    assign bb_maddr[1] = bus15.mem_addr;
    assign bb_rdata[0] = bus1.if_rdata;
    assign bb_rdata[1] = bus15.if_rdata;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] dat_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge with the DUT idle; returns just after the RESP->IDLE edge.
    task automatic do_access(input logic is_dm, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata,
                             output int ack_at, output int en_at, output int n_en,
                             output int n_wrong, output logic [31:0] en_addr,
                             output logic en_we, output logic [31:0] en_wdata);
        ack_at = -1; en_at = -1; n_en = 0; n_wrong = 0;
        en_addr = '0; en_we = 1'b0; en_wdata = '0;
        if (is_dm) begin
            bus2.dm_req = 1'b1; bus2.dm_we = we; bus2.dm_addr = addr; bus2.dm_wdata = wdata;
        end else begin
            bus2.if_req = 1'b1; bus2.if_addr = addr;
        end
        for (int k = 1; k <= 30 && ack_at < 0; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus2.mem_en) begin
                n_en++;
                if (en_at < 0) begin
                    en_at = k; en_addr = bus2.mem_addr; en_we = bus2.mem_we;
                    en_wdata = bus2.mem_wdata;
                end
                // Scramble the request fields after grant; they must not matter any more.
                bus2.if_addr  = 32'h0000_00EE;
                bus2.dm_addr  = 32'h0000_00EE;
                bus2.dm_we    = ~we;
                bus2.dm_wdata = 32'h0;
            end
            if (is_dm ? bus2.dm_ack : bus2.if_ack) ack_at = k;
            if (is_dm ? bus2.if_ack : bus2.dm_ack) n_wrong++;
        end
        bus2.if_req = 1'b0;
        bus2.dm_req = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic bb_drive(input int sel, input logic req, input logic [31:0] addr);
        if (sel == 0) begin
            bus1.if_req = req; bus1.if_addr = addr;
        end else begin
            bus15.if_req = req; bus15.if_addr = addr;
        end
    endtask

    // Three back-to-back fetches with if_req held high throughout.
    task automatic bb_run(input int sel, input int lat);
        int prev_en, n_en, n_ack, first_ack;
        logic [31:0] a;
        exp_q = {32'h50, 32'h51, 32'h52};
        dat_q = {32'hC050_0F50, 32'hC051_0F51, 32'hC052_0F52};
        prev_en = -1; n_en = 0; n_ack = 0; first_ack = -1;
        bb_drive(sel, 1'b1, 32'h50);
        for (int k = 1; k <= 80 && n_ack < 3; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bb_en[sel]) begin
                n_en++;
                if (prev_en >= 0) check($sformatf("bb%0d_period", lat), k - prev_en, lat + 3);
                prev_en = k;
                if (exp_q.size() > 0) begin
                    a = exp_q.pop_front();
                    check($sformatf("bb%0d_issue_addr", lat), bb_maddr[sel], a);
                end
                bb_drive(sel, 1'b1, 32'h0000_00EE);
            end
            if (bb_ack[sel]) begin
                n_ack++;
                if (first_ack < 0) begin
                    first_ack = k;
                    check($sformatf("bb%0d_first_ack", lat), k, lat + 2);
                end
                if (dat_q.size() > 0) check($sformatf("bb%0d_rdata", lat), bb_rdata[sel], dat_q.pop_front());
                if (n_ack == 1)      bb_drive(sel, 1'b1, 32'h51);
                else if (n_ack == 2) bb_drive(sel, 1'b1, 32'h52);
                else                 bb_drive(sel, 1'b0, 32'h0);
            end
        end
        check($sformatf("bb%0d_acks", lat), n_ack, 3);
        check($sformatf("bb%0d_grants", lat), n_en, 3);
        @(posedge clock);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ack_at, en_at, n_en, n_wrong, dm_ack_at, if_ack_at, dm_acks, both;
        logic if_done;
        logic [31:0] en_addr, en_wdata, a;
        logic en_we;

        reset_n = 1'b0;
        bus2.if_req = 1'b0; bus2.if_addr = '0;
        bus2.dm_req = 1'b0; bus2.dm_we = 1'b0; bus2.dm_addr = '0; bus2.dm_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.dm_req = 1'b0; bus1.dm_we = 1'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
        bus15.if_req = 1'b0; bus15.if_addr = '0;
        bus15.dm_req = 1'b0; bus15.dm_we = 1'b0; bus15.dm_addr = '0; bus15.dm_wdata = '0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ctrl", 32'({bus2.mem_en, bus2.mem_we, bus2.busy, bus2.owner_dm,
                               bus2.if_ack, bus2.dm_ack}), 32'h0);
        check("rst_mem_addr", bus2.mem_addr, 32'h0);
        check("rst_if_rdata", bus2.if_rdata, 32'h0);
        check("rst_state_streak", 32'({state2, streak2}), 32'h0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single fetch
        do_access(1'b0, 1'b0, 32'h10, 32'h0, ack_at, en_at, n_en, n_wrong, en_addr, en_we, en_wdata);
        check("fetch_ack_cycle", ack_at, 4);
        check("fetch_en_cycle", en_at, 1);
        check("fetch_en_count", n_en, 1);
        check("fetch_en_addr", en_addr, 32'h10);
        check("fetch_en_we", 32'(en_we), 32'h0);
        check("fetch_other_ack", n_wrong, 0);
        check("fetch_rdata", bus2.if_rdata, 32'hDEAD_BEEF);
        check("fetch_idle", 32'({bus2.busy, state2}), 32'h0);

        // Same-edge contention
        exp_q = {32'h40, 32'h20};
        bus2.if_req = 1'b1; bus2.if_addr = 32'h20;
        bus2.dm_req = 1'b1; bus2.dm_we = 1'b0; bus2.dm_addr = 32'h40;
        n_en = 0; dm_ack_at = -1; if_ack_at = -1; both = 0;
        for (int k = 1; k <= 40 && (dm_ack_at < 0 || if_ack_at < 0); k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus2.mem_en) begin
                n_en++;
                if (exp_q.size() > 0) begin
                    a = exp_q.pop_front();
                    check("cont_grant_addr", bus2.mem_addr, a);
                    check("cont_owner", 32'(bus2.owner_dm), 32'(a == 32'h40));
                end
            end
            if (bus2.dm_ack && bus2.if_ack) both++;
            if (bus2.dm_ack) begin dm_ack_at = k; bus2.dm_req = 1'b0; end
            if (bus2.if_ack) begin if_ack_at = k; bus2.if_req = 1'b0; end
        end
        check("cont_dm_ack_cycle", dm_ack_at, 4);
        check("cont_if_ack_cycle", if_ack_at, 9);
        check("cont_en_count", n_en, 2);
        check("cont_both_acks", both, 0);
        check("cont_dm_rdata", bus2.dm_rdata, 32'hCAFE_F00D);
        check("cont_if_rdata", bus2.if_rdata, 32'hC020_0F20);
        check("cont_streak", 32'(streak2), 32'h0);
        @(posedge clock);
        #1;

        // Starvation guard: owners dm,dm,dm,if,dm
        exp_q = {32'h1, 32'h1, 32'h1, 32'h0, 32'h1};
        bus2.dm_req = 1'b1; bus2.dm_we = 1'b0; bus2.dm_addr = 32'h40;
        bus2.if_req = 1'b1; bus2.if_addr = 32'h10;
        n_en = 0; dm_acks = 0; if_done = 1'b0;
        for (int k = 1; k <= 60 && !(dm_acks == 4 && if_done); k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus2.mem_en) begin
                n_en++;
                if (exp_q.size() > 0) begin
                    a = exp_q.pop_front();
                    check($sformatf("starve_owner_%0d", n_en), 32'(bus2.owner_dm), a);
                end
                if (n_en == 3) check("starve_streak_sat", 32'(streak2), 32'd3);
                if (n_en == 4) check("starve_streak_after_if", 32'(streak2), 32'd0);
            end
            if (bus2.dm_ack) begin
                dm_acks++;
                if (dm_acks == 4) bus2.dm_req = 1'b0;
            end
            if (bus2.if_ack) begin if_done = 1'b1; bus2.if_req = 1'b0; end
        end
        check("starve_grants", n_en, 5);
        check("starve_q_empty", exp_q.size(), 0);
        @(posedge clock);
        #1;

        // Write, then read back
        do_access(1'b1, 1'b1, 32'h8, 32'h1234_5678, ack_at, en_at, n_en, n_wrong, en_addr, en_we, en_wdata);
        check("wr_ack_cycle", ack_at, 4);
        check("wr_en_we", 32'(en_we), 32'h1);
        check("wr_en_addr", en_addr, 32'h8);
        check("wr_en_wdata", en_wdata, 32'h1234_5678);
        check("wr_en_count", n_en, 1);
        check("wr_dm_rdata_kept", bus2.dm_rdata, 32'hCAFE_F00D);
        do_access(1'b1, 1'b0, 32'h8, 32'h0, ack_at, en_at, n_en, n_wrong, en_addr, en_we, en_wdata);
        check("rdback_ack_cycle", ack_at, 4);
        check("rdback_dm_rdata", bus2.dm_rdata, 32'h1234_5678);

        // Reset mid-WAIT
        bus2.if_req = 1'b1; bus2.if_addr = 32'h30;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("rstw_pre_state", 32'(state2), 32'd2);
        reset_n = 1'b0;
        #1;
        check("rstw_ctrl", 32'({bus2.mem_en, bus2.mem_we, bus2.busy, bus2.owner_dm,
                                bus2.if_ack, bus2.dm_ack}), 32'h0);
        check("rstw_if_rdata", bus2.if_rdata, 32'h0);
        check("rstw_dm_rdata", bus2.dm_rdata, 32'h0);
        check("rstw_mem_addr", bus2.mem_addr, 32'h0);
        @(posedge clock);
        @(negedge clock);
        check("rstw_held", 32'({bus2.if_ack, bus2.busy, state2}), 32'h0);
        reset_n = 1'b1;
        ack_at = -1; n_en = 0;
        for (int k = 1; k <= 20 && ack_at < 0; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus2.mem_en) n_en++;
            if (bus2.if_ack) ack_at = k;
        end
        check("rstw_reissue_ack", ack_at, 4);
        check("rstw_reissue_en", n_en, 1);
        check("rstw_reissue_rdata", bus2.if_rdata, 32'hC030_0F30);
        bus2.if_req = 1'b0;
        @(posedge clock);
        #1;

        // Back-to-back fetches at both latency extremes
        bb_run(0, 1);
        bb_run(1, 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
